imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_pkg.sv | 30 +++
 rtl/imem_fetch_ctrl_if.sv | 35 +++
 rtl/fetch_fifo.sv | 112 +++++++++++
 rtl/imem_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction fetch sequencer.
//   state_t       : fetch sequencer state (RUN / HALTED / FAULT)
//   fetch_entry_t : one prefetch FIFO entry, {pc, inst}
//   word_index()  : byte address to instruction memory word index
// -----------------------------------------------------------------------------
package imem_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    localparam int          IMEM_DEPTH_DEF = 128;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] PC_STEP        = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // The memory is word-indexed; byte addresses drop their two low bits.
    function automatic logic [29:0] word_index(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Groups the fetch sequencer's memory, control and decode-side signals.
//   imem_addr/imem_rdata     : combinational instruction memory read port
//   redirect_valid/_pc, halt : control from the execute stage
//   inst_valid/data/pc/ready : valid/ready handshake toward decode
//   fault, halted            : status
// modport master : the fetch sequencer
// modport slave  : the surrounding core (memory, execute, decode)
// -----------------------------------------------------------------------------
interface imem_fetch_ctrl_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fault;
    logic        halted;

    modport master (
        output imem_addr, inst_valid, inst_data, inst_pc, fault, halted,
        input  imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst_data, inst_pc, fault, halted,
        output imem_rdata, redirect_valid, redirect_pc, halt, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Prefetch FIFO holding {pc, inst} entries with a registered head.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush_i        : synchronous flush; overrides push and pop
//   push_i         : write push_entry_i (accepted when full only with a pop)
//   push_entry_i   : entry to write
//   pop_i          : advance the head (ignored when empty)
//   full_o/empty_o : occupancy flags
//   head_valid_o   : head entry is valid
//   head_entry_o   : head entry, all zero when empty
// -----------------------------------------------------------------------------
module fetch_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic         empty_o,
    output logic         head_valid_o,
    output fetch_entry_t head_entry_o
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          head_valid_q, head_valid_d;
    fetch_entry_t  head_q, head_d;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign do_pop  = pop_i && !flush_i && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && !flush_i && (!full || do_pop);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_valid_d = 1'b0;
        head_d       = '0;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            // Next head comes from storage unless the slot it lands on is
            // the one being written this very cycle.
            if (count_d != '0) begin
                head_valid_d = 1'b1;
                if (do_push && (wr_ptr_q == rd_ptr_d)) head_d = push_entry_i;
                else                                   head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_q       <= head_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define which slots are meaningful, and the head register is reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign full_o       = full;
    assign empty_o      = (count_q == '0);
    assign head_valid_o = head_valid_q;
    assign head_entry_o = head_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer for the word-indexed instruction memory. Owns the PC,
// drives the memory address, captures {pc, inst} into a prefetch FIFO and
// presents the FIFO head to decode over valid/ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_fetch_ctrl_if.master
//                imem_addr (= PC), imem_rdata, redirect_valid/redirect_pc,
//                halt, inst_valid/inst_data/inst_pc/inst_ready, fault, halted
// Per-cycle priority: reset > redirect > range fault > halt > push.
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    imem_fetch_ctrl_if.master bus
);

    // Range check in words avoids overflow of IMEM_DEPTH*4 near the top.
    localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

    state_t       state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic         redirect;
    logic         redirect_misaligned;
    logic         in_range;
    logic         pop;
    logic         push;
    fetch_entry_t push_entry;

    logic         fifo_full;
    logic         fifo_empty;
    logic         head_valid;
    fetch_entry_t head_entry;

    // A redirect in FAULT is ignored entirely: no flush, no PC change.
    assign redirect            = bus.redirect_valid && (state_q != FAULT);
    assign redirect_misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign in_range            = (word_index(pc_q) < DEPTH_WORDS);
    assign pop                 = head_valid && bus.inst_ready;

    assign push = (state_q == RUN) && !redirect && in_range && !bus.halt
                  && (!fifo_full || pop);

    assign push_entry = '{pc: pc_q, inst: bus.imem_rdata};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;

        if (redirect) begin
            if (redirect_misaligned) begin
                state_d = FAULT;
            end else begin
                pc_d    = bus.redirect_pc;
                // Redirect wins for PC/flush; a concurrent halt still parks us.
                state_d = bus.halt ? HALTED : RUN;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (!in_range)    state_d = FAULT;
                    else if (bus.halt) state_d = HALTED;
                    else if (push)    pc_d    = pc_q + PC_STEP;
                end
                HALTED: begin
                    if (!bus.halt) state_d = RUN;
                end
                FAULT:   state_d = FAULT;
                default: state_d = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .head_valid_o (head_valid),
        .head_entry_o (head_entry)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst_data  = head_entry.inst;
    assign bus.inst_pc    = head_entry.pc;
    assign bus.fault      = (state_q == FAULT);
    assign bus.halted     = (state_q == HALTED) && fifo_empty;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl. Memory word n holds 32'h1000_0000+n.
// Expected deliveries are queued as stimulus is applied; a negedge monitor
// pops and compares each accepted instruction.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;
    import imem_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_DEPTH (128),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Combinational instruction memory model.
    assign bus.imem_rdata = 32'h1000_0000 + {2'b00, word_index(bus.imem_addr)};

    int           vectors     = 0;
    int           miscompares = 0;
    fetch_entry_t sb_q [$];
    fetch_entry_t want_e;
    logic         exp_fault   = 1'b0;

    function automatic fetch_entry_t expected_entry(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = 32'h1000_0000 + {2'b00, pc[31:2]};
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vectors++;
        assert (obs === want)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pcs(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(expected_entry(first + 32'(4 * i)));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst_n     = 1'b0;
        exp_fault = 1'b0;
        sb_q.delete();
        #2;
        check("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        check("rst_inst_data",  64'(bus.inst_data),  64'd0);
        check("rst_inst_pc",    64'(bus.inst_pc),    64'd0);
        check("rst_fault",      64'(bus.fault),      64'd0);
        check("rst_halted",     64'(bus.halted),     64'd0);
        check("rst_imem_addr",  64'(bus.imem_addr),  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // A transfer happens at the next posedge when valid&&ready; a redirect
    // outside FAULT flushes the head instead of consuming it.
    always @(negedge clk) begin
        if (rst_n && bus.inst_valid && bus.inst_ready && !(bus.redirect_valid && !exp_fault)) begin
            vectors++;
            assert (sb_q.size() != 0)
            else begin
                miscompares++;
                $error("FAIL sb_unexpected: observed pc %0h expected no delivery", bus.inst_pc);
            end
            if (sb_q.size() != 0) begin
                want_e = sb_q.pop_front();
                check("deliver_pc",   64'(bus.inst_pc),   64'(want_e.pc));
                check("deliver_data", 64'(bus.inst_data), 64'(want_e.inst));
            end
        end
    end

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.halt           = 1'b0;
        bus.inst_ready     = 1'b0;
        #1;

        // 1) Stream from reset with decode always ready.
        bus.inst_ready = 1'b1;
        pulse_reset();
        check("valid_before_first_edge", 64'(bus.inst_valid), 64'd0);
        expect_pcs(32'h0, 8);
        step();
        check("first_valid", 64'(bus.inst_valid), 64'd1);
        check("first_pc",    64'(bus.inst_pc),    64'd0);
        drain(40);
        bus.inst_ready = 1'b0;

        // 2) Backpressure: FIFO fills with 0 and 4, PC stops at 8.
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_head_pc", 64'(bus.inst_pc), 64'd0);
        end
        check("stall_valid", 64'(bus.inst_valid), 64'd1);
        check("stall_data",  64'(bus.inst_data),  64'h1000_0000);
        check("stall_addr",  64'(bus.imem_addr),  64'h8);
        expect_pcs(32'h0, 3);
        bus.inst_ready = 1'b1;
        drain(20);
        bus.inst_ready = 1'b0;
        check("post_stall_addr", 64'(bus.imem_addr), 64'd20);
        check("post_stall_head", 64'(bus.inst_pc),   64'd12);

        // 3) Redirect with two entries held and pop asserted.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.inst_ready     = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("redir_flush_valid", 64'(bus.inst_valid), 64'd0);
        check("redir_addr",        64'(bus.imem_addr),  64'h40);
        expect_pcs(32'h40, 3);
        drain(20);
        bus.inst_ready = 1'b0;
        check("redir_head", 64'(bus.inst_pc),   64'h4C);
        check("redir_pc",   64'(bus.imem_addr), 64'h50);

        // 4) Halt while streaming: drain, halted, then resume at same PC.
        bus.halt = 1'b1;
        step();
        check("halt_draining", 64'(bus.halted),    64'd0);
        check("halt_addr",     64'(bus.imem_addr), 64'h50);
        expect_pcs(32'h4C, 1);
        bus.inst_ready = 1'b1;
        drain(10);
        check("halted_set",   64'(bus.halted),     64'd1);
        check("halted_valid", 64'(bus.inst_valid), 64'd0);
        step();
        step();
        check("halted_hold",  64'(bus.halted),     64'd1);
        check("halted_pc",    64'(bus.imem_addr),  64'h50);
        bus.halt = 1'b0;
        expect_pcs(32'h50, 3);
        drain(20);
        bus.inst_ready = 1'b0;
        check("resume_halted", 64'(bus.halted), 64'd0);

        // 5) Redirect + halt in the same cycle.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h80;
        bus.halt           = 1'b1;
        bus.inst_ready     = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        check("rh_halted", 64'(bus.halted),     64'd1);
        check("rh_valid",  64'(bus.inst_valid), 64'd0);
        check("rh_addr",   64'(bus.imem_addr),  64'h80);
        step();
        step();
        check("rh_hold_addr", 64'(bus.imem_addr), 64'h80);
        bus.halt = 1'b0;
        expect_pcs(32'h80, 1);
        drain(10);
        bus.inst_ready = 1'b0;

        // 6) Run off the end of memory from 0x1F0.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h1F0;
        bus.inst_ready     = 1'b1;
        step();
        bus.redirect_valid = 1'b0;
        expect_pcs(32'h1F0, 4);
        drain(20);
        check("range_fault", 64'(bus.fault),      64'd1);
        check("range_valid", 64'(bus.inst_valid), 64'd0);
        check("range_addr",  64'(bus.imem_addr),  64'h200);
        exp_fault = 1'b1;
        step();
        step();
        step();
        check("range_no_fetch", 64'(bus.inst_valid), 64'd0);
        bus.inst_ready = 1'b0;

        // 7) Misaligned redirect faults; later redirects ignored until reset.
        pulse_reset();
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h42;
        step();
        bus.redirect_valid = 1'b0;
        exp_fault = 1'b1;
        check("misalign_fault", 64'(bus.fault),      64'd1);
        check("misalign_valid", 64'(bus.inst_valid), 64'd0);
        check("misalign_addr",  64'(bus.imem_addr),  64'h8);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        check("ignored_fault", 64'(bus.fault),      64'd1);
        check("ignored_addr",  64'(bus.imem_addr),  64'h8);
        check("ignored_valid", 64'(bus.inst_valid), 64'd0);
        bus.inst_ready = 1'b0;
        pulse_reset();
        step();
        check("recover_valid", 64'(bus.inst_valid), 64'd1);
        check("recover_pc",    64'(bus.inst_pc),    64'd0);
        check("recover_fault", 64'(bus.fault),      64'd0);

        check("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
